// File: rtl/sm83_bus_pkg.sv
// sm83_bus_pkg
// Shared definitions for the SM83 external-bus target:
//   bus_state_t    - machine-cycle tracking states of the target FSM
//   OPEN_BUS_DATA  - value presented on a read that nobody answers (all ones;
//                    slice to the data width at the point of use)
//   window_hit()   - true when an address falls in a power-of-two aligned window
package sm83_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } bus_state_t;

  localparam logic [63:0] OPEN_BUS_DATA = '1;

  // Compares only the bits above the window size, so the window must be
  // aligned to its own size. Arguments are zero-extended to 32 bits by the
  // caller so one function serves any bus width up to 32.
  function automatic logic window_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int unsigned mem_bits);
    return (adr >> mem_bits) == (base >> mem_bits);
  endfunction

endpackage

// File: rtl/sm83_bus_target_ram.sv
// sm83_bus_target_ram
// Single-port synchronous RAM backing the target's memory window.
// Ports:
//   clk    in   clock, write and read both on posedge
//   we     in   write enable: mem[adr] <= wdata
//   re     in   read enable: rdata <= mem[adr]
//   adr    in   word address (ADR_W bits)
//   wdata  in   write data (DATA_W bits)
//   rdata  out  registered read data; holds its value while re is low
// Contents are not reset.
module sm83_bus_target_ram
  import sm83_bus_pkg::*;
#(
  parameter int unsigned ADR_W  = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[adr] <= wdata;
    end
    if (re) begin
      rdata <= mem[adr];
    end
  end

endmodule

// File: rtl/sm83_bus_target.sv
// sm83_bus_target
// Slave end of the SM83 pin-level bus cycle. Follows the T-state phases,
// latches the address at T2, answers reads at T3 (data held through the CPU's
// T4 sample) and commits writes captured at T3 into a small RAM window at T4.
//
// Optional feature macro: SM83_BUS_TARGET_WPROT_EN
//   defined   - the bottom WPROT_WORDS words of the window are read-only;
//               dropped writes pulse wprot_viol for one cycle
//   undefined - whole window writable, wprot_viol tied low
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high
//   t1..t4         in   one-hot T-state phase
//   aout           in   CPU address pins
//   ext_dout       in   CPU write data pins
//   ext_data_lh    in   CPU read-latch strobe (T3 of a read)
//   n_rd,p_rd      in   CPU read strobes
//   n_wr,p_wr      in   CPU write strobes
//   ext_din        out  read data to the CPU (all ones when not answering)
//   hit            out  latched address lies in the window
//   wprot_viol     out  one-cycle pulse when a protected write is dropped
//   proto_err      out  sticky protocol-error flag, cleared only by reset
module sm83_bus_target
  import sm83_bus_pkg::*;
#(
  parameter int unsigned             ADR_WIDTH     = 16,
  parameter int unsigned             WORD_SIZE     = 8,
  parameter int unsigned             MEM_ADR_WIDTH = 7,
  parameter logic [ADR_WIDTH-1:0]    BASE_ADR      = 16'hff80,
  parameter int unsigned             WPROT_WORDS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 t1,
  input  logic                 t2,
  input  logic                 t3,
  input  logic                 t4,
  input  logic [ADR_WIDTH-1:0] aout,
  input  logic [WORD_SIZE-1:0] ext_dout,
  input  logic                 ext_data_lh,
  input  logic                 n_rd,
  input  logic                 p_rd,
  input  logic                 n_wr,
  input  logic                 p_wr,
  output logic [WORD_SIZE-1:0] ext_din,
  output logic                 hit,
  output logic                 wprot_viol,
  output logic                 proto_err
);

  bus_state_t state, state_next;

  logic [ADR_WIDTH-1:0]     addr_q;
  logic [WORD_SIZE-1:0]     wdata_q;
  logic                     hit_q;
  logic                     rd_hit_q;
  logic                     proto_err_q;
  logic                     wprot_viol_q;

  logic                     proto_now;
  logic                     is_protected;
  logic                     latch_addr;
  logic                     do_read;
  logic                     latch_wdata;
  logic                     commit;
  logic                     suppress;
  logic [MEM_ADR_WIDTH-1:0] offset;
  logic [WORD_SIZE-1:0]     ram_rdata;

  // T1 carries no work for a target, and the read direction is fully
  // described by ext_data_lh / n_rd.
  logic unused_pins;
  assign unused_pins = t1 ^ p_rd;

  assign offset = addr_q[MEM_ADR_WIDTH-1:0];

  // Illegal strobe combinations, evaluated every cycle.
  assign proto_now = (ext_data_lh && n_wr)
                   || (n_wr && !t3)
                   || (ext_data_lh && !t3)
                   || (n_wr && !p_wr);

`ifdef SM83_BUS_TARGET_WPROT_EN
  assign is_protected = (32'(offset) < 32'(WPROT_WORDS));
`else
  assign is_protected = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next  = state;
    latch_addr  = 1'b0;
    do_read     = 1'b0;
    latch_wdata = 1'b0;
    commit      = 1'b0;
    suppress    = 1'b0;
    case (state)
      IDLE: begin
        if (t2) begin
          state_next = ADDR;
          latch_addr = 1'b1;
        end
      end
      ADDR: begin
        if (t3) begin
          if (proto_now) begin
            // Abandon the cycle: no read update, no write capture.
            state_next = IDLE;
          end else if (ext_data_lh) begin
            state_next = READ;
            do_read    = 1'b1;
          end else if (n_wr && !n_rd) begin
            state_next  = WRITE;
            latch_wdata = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      READ: begin
        if (t4) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (t4) begin
          state_next = IDLE;
          commit     = hit_q && !is_protected;
          suppress   = hit_q && is_protected;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      hit_q        <= 1'b0;
      rd_hit_q     <= 1'b0;
      proto_err_q  <= 1'b0;
      wprot_viol_q <= 1'b0;
    end else begin
      if (latch_addr) begin
        addr_q <= aout;
        hit_q  <= window_hit(32'(aout), 32'(BASE_ADR), MEM_ADR_WIDTH);
      end
      if (latch_wdata) begin
        wdata_q <= ext_dout;
      end
      // Remembers whether the last answered read came from the window; the
      // RAM read register itself is not reset, so open-bus is produced here.
      if (do_read) begin
        rd_hit_q <= hit_q;
      end
      if (proto_now) begin
        proto_err_q <= 1'b1;
      end
      wprot_viol_q <= suppress;
    end
  end

  // Read and write share the one RAM port: reads only in ADDR at T3, writes
  // only in WRITE at T4, so they never collide.
  sm83_bus_target_ram #(
    .ADR_W  (MEM_ADR_WIDTH),
    .DATA_W (WORD_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .re    (do_read),
    .adr   (offset),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign ext_din    = rd_hit_q ? ram_rdata : OPEN_BUS_DATA[WORD_SIZE-1:0];
  assign hit        = hit_q;
  assign wprot_viol = wprot_viol_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_sm83_bus_target.sv
// tb_sm83_bus_target
// Directed bench for sm83_bus_target: drives full SM83 machine cycles,
// keeps a byte model of the memory window, and queues expected read results
// at T3 for comparison during T4.
module tb_sm83_bus_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        t1, t2, t3, t4;
  logic [15:0] aout;
  logic [7:0]  ext_dout;
  logic        ext_data_lh;
  logic        n_rd, p_rd, n_wr, p_wr;
  logic [7:0]  ext_din;
  logic        hit;
  logic        wprot_viol;
  logic        proto_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_mem [int];
  logic [8:0] sb_q [$];   // {expected hit, expected data}

  always #5 clk = ~clk;

  sm83_bus_target dut (
    .clk         (clk),
    .reset       (reset),
    .t1          (t1),
    .t2          (t2),
    .t3          (t3),
    .t4          (t4),
    .aout        (aout),
    .ext_dout    (ext_dout),
    .ext_data_lh (ext_data_lh),
    .n_rd        (n_rd),
    .p_rd        (p_rd),
    .n_wr        (n_wr),
    .p_wr        (p_wr),
    .ext_din     (ext_din),
    .hit         (hit),
    .wprot_viol  (wprot_viol),
    .proto_err   (proto_err)
  );

  function automatic logic in_win(input logic [15:0] a);
    return a >= 16'hff80;
  endfunction

  function automatic logic is_prot(input logic [15:0] a);
`ifdef SM83_BUS_TARGET_WPROT_EN
    return in_win(a) && (a[6:0] < 7'd16);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic phase(input int p);
    t1 = (p == 1);
    t2 = (p == 2);
    t3 = (p == 3);
    t4 = (p == 4);
  endtask

  task automatic strobes_off();
    ext_data_lh = 1'b0;
    n_rd = 1'b0;
    p_rd = 1'b0;
    n_wr = 1'b0;
    p_wr = 1'b0;
  endtask

  task automatic read_cycle(input logic [15:0] a);
    logic [8:0] e;
    @(negedge clk); phase(1); aout = a; strobes_off();
    @(negedge clk); phase(2);
    @(negedge clk); phase(3); ext_data_lh = 1'b1; n_rd = 1'b1; p_rd = 1'b1;
    sb_q.push_back({in_win(a), in_win(a) ? model_mem[int'(a[6:0])] : 8'hff});
    @(negedge clk); phase(4); strobes_off();
    e = sb_q.pop_front();
    check($sformatf("rd_data@%h", a), 32'(ext_din), 32'(e[7:0]));
    check($sformatf("rd_hit@%h", a), 32'(hit), 32'(e[8]));
    $display("read  %h -> %h (hit %0b)", a, ext_din, hit);
    @(posedge clk); #1;
    check($sformatf("rd_hold@%h", a), 32'(ext_din), 32'(e[7:0]));
  endtask

  task automatic write_cycle(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); phase(1); aout = a; strobes_off();
    @(negedge clk); phase(2);
    @(negedge clk); phase(3); n_wr = 1'b1; p_wr = 1'b1; ext_dout = d;
    @(negedge clk); phase(4); strobes_off();
    check($sformatf("wr_hit@%h", a), 32'(hit), 32'(in_win(a)));
    @(posedge clk); #1;
    check($sformatf("wr_viol@%h", a), 32'(wprot_viol), 32'(is_prot(a)));
    if (in_win(a) && !is_prot(a)) model_mem[int'(a[6:0])] = d;
    $display("write %h <- %h (hit %0b, viol %0b)", a, d, hit, wprot_viol);
  endtask

  initial begin
    reset = 1'b1;
    phase(1);
    aout = 16'h0000;
    ext_dout = 8'h00;
    strobes_off();
    repeat (3) @(negedge clk);
    check("rst_ext_din", 32'(ext_din), 32'h0000_00ff);
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_viol", 32'(wprot_viol), 32'h0);
    check("rst_perr", 32'(proto_err), 32'h0);
    reset = 1'b0;

    // Basic write / read-back inside the window
    write_cycle(16'hff90, 8'h5a);
    read_cycle(16'hff90);

    // Miss reads return open bus; a miss write must not alias into the window
    read_cycle(16'hc000);
    write_cycle(16'hffa5, 8'h3c);
    write_cycle(16'hc025, 8'h12);
    read_cycle(16'hffa5);

    // Window edges
    write_cycle(16'hffff, 8'h9d);
    read_cycle(16'hffff);
    read_cycle(16'hff7f);

    // Protected region (or plain write in the default build)
    write_cycle(16'hff85, 8'h33);
    @(posedge clk); #1;
    check("viol_pulse_end", 32'(wprot_viol), 32'h0);
`ifndef SM83_BUS_TARGET_WPROT_EN
    read_cycle(16'hff85);
`endif
    write_cycle(16'hff95, 8'hc7);
    read_cycle(16'hff95);

    // Back-to-back write then read, no idle cycle between
    write_cycle(16'hffa0, 8'ha5);
    read_cycle(16'hffa0);

    // Reset during T3/T4 of a write aborts it
    @(negedge clk); phase(1); aout = 16'hffa0; strobes_off();
    @(negedge clk); phase(2);
    @(negedge clk); phase(3); n_wr = 1'b1; p_wr = 1'b1; ext_dout = 8'h77;
    @(negedge clk); phase(4); strobes_off(); reset = 1'b1;
    #1;
    check("abort_ext_din", 32'(ext_din), 32'h0000_00ff);
    check("abort_hit", 32'(hit), 32'h0);
    check("abort_viol", 32'(wprot_viol), 32'h0);
    check("abort_perr", 32'(proto_err), 32'h0);
    $display("reset during write of 77 to ffa0");
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    read_cycle(16'hffa0);

    // Protocol error: read latch and write strobe together at T3
    @(negedge clk); phase(1); aout = 16'hff90; strobes_off();
    @(negedge clk); phase(2);
    @(negedge clk); phase(3); ext_data_lh = 1'b1; n_wr = 1'b1; p_wr = 1'b1; ext_dout = 8'hee;
    @(negedge clk); phase(4); strobes_off();
    check("perr_set", 32'(proto_err), 32'h1);
    $display("conflicting strobes at ff90 -> proto_err %0b", proto_err);
    @(posedge clk); #1;
    read_cycle(16'hff90);
    check("perr_sticky", 32'(proto_err), 32'h1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("perr_cleared", 32'(proto_err), 32'h0);
    $display("reset -> proto_err %0b", proto_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
